// File: rtl/conv_row_engine.sv
// 3x3 zero-padded convolution over a BRAM-resident image, one result row per clock.
// Rows stream through a top/mid/bot window; each result row is computed combinationally and registered.
module conv_row_engine #(
  parameter int ROWS   = 128,
  parameter int COLS   = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8,
  parameter int SHIFT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [71:0]             kernel,
  output logic [ADDR_W-1:0]       bram1_address,
  output logic                    bram1_en,
  input  logic [COLS*PIX_W-1:0]   bram1_dout,
  output logic [COLS*PIX_W-1:0]   data_out,
  output logic                    data_valid,
  output logic [ADDR_W-1:0]       row_index,
  output logic                    done,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int ROW_W = COLS * PIX_W;
  localparam int ACC_W = 20;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] ZERO_SHIFT = CNT_W'(ROWS + 1);
  localparam logic [CNT_W-1:0] OUT_FIRST  = CNT_W'(3);
  localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(ROWS + 2);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               en_q;
  logic               busy_q;
  logic [71:0]        kernel_q;

  logic [ROW_W-1:0]   top_q, mid_q, bot_q;
  logic [ROW_W-1:0]   data_out_q;
  logic               data_valid_q;
  logic [ADDR_W-1:0]  row_index_q;
  logic               done_q;

  logic               start_acc;
  logic               running;
  logic               shift_en;
  logic               zero_shift;
  logic               out_en;
  logic [ROW_W-1:0]   row_d;

  // cnt_q = n in cycle S+1+n; all window/output timing keys off it.
  assign start_acc  = (state_q == S_IDLE) && start;
  assign running    = (state_q == S_FETCH) || (state_q == S_FLUSH);
  assign shift_en   = running && (cnt_q >= CNT_W'(1)) && (cnt_q <= LAST_SHIFT);
  assign zero_shift = (state_q == S_FLUSH) && (cnt_q == ZERO_SHIFT);
  assign out_en     = running && (cnt_q >= OUT_FIRST) && (cnt_q <= OUT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      kernel_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_FETCH;
            cnt_q    <= '0;
            addr_q   <= '0;
            en_q     <= 1'b1;
            busy_q   <= 1'b1;
            kernel_q <= kernel;
          end
        end
        S_FETCH: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ADDR) begin
            en_q    <= 1'b0;
            state_q <= S_FLUSH;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_FLUSH: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == OUT_LAST) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  function automatic logic signed [ACC_W-1:0] tap(input logic [PIX_W-1:0] p,
                                                  input logic [7:0] k);
    logic signed [ACC_W-1:0] pe;
    logic signed [ACC_W-1:0] ke;
    pe = $signed({{(ACC_W-PIX_W){1'b0}}, p});
    ke = $signed({{(ACC_W-8){k[7]}}, k});
    return pe * ke;
  endfunction

  logic [ROW_W-1:0]        win_row;
  logic [PIX_W-1:0]        px;
  logic [PIX_W-1:0]        pix;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;

  // Columns outside 0..COLS-1 contribute zero; rows are padded by the window contents.
  always_comb begin
    row_d   = '0;
    win_row = '0;
    px      = '0;
    pix     = '0;
    acc     = '0;
    shifted = '0;
    for (int c = 0; c < COLS; c++) begin
      acc = '0;
      for (int ky = 0; ky < 3; ky++) begin
        win_row = (ky == 0) ? top_q : ((ky == 1) ? mid_q : bot_q);
        for (int kx = 0; kx < 3; kx++) begin
          px = '0;
          if ((c + kx >= 1) && (c + kx <= COLS)) begin
            px = win_row[(c + kx - 1) * PIX_W +: PIX_W];
          end
          acc = acc + tap(px, kernel_q[(3 * ky + kx) * 8 +: 8]);
        end
      end
      shifted = acc >>> SHIFT;
      if (shifted[ACC_W-1]) begin
        pix = '0;
      end else if (shifted > PIX_MAX) begin
        pix = '1;
      end else begin
        pix = shifted[PIX_W-1:0];
      end
      row_d[c * PIX_W +: PIX_W] = pix;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      row_index_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      if (start_acc) begin
        top_q <= '0;
        mid_q <= '0;
        bot_q <= '0;
      end else if (shift_en) begin
        top_q <= mid_q;
        mid_q <= bot_q;
        bot_q <= bram1_dout;
      end else if (zero_shift) begin
        top_q <= mid_q;
        mid_q <= bot_q;
        bot_q <= '0;
      end
      data_valid_q <= out_en;
      done_q       <= out_en && (cnt_q == OUT_LAST);
      if (out_en) begin
        data_out_q  <= row_d;
        row_index_q <= ADDR_W'(cnt_q - OUT_FIRST);
      end
    end
  end

  assign bram1_address = addr_q;
  assign bram1_en      = en_q;
  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign row_index     = row_index_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule
